// File: rtl/cache_2vias_wb_pkg.sv
// Shared types for the 2-way write-back cache: controller states and the
// per-field write enables of one way's line storage.
package cache_pkg;

    localparam int NUM_VIAS = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        RESPOND   = 3'd4
    } state_e;

    // Line layout is {lru, val, dirty, tag, data}; lru is per set in the top,
    // the remaining fields are per way and individually writable.
    typedef struct packed {
        logic val;
        logic dirty;
        logic tag;
        logic data;
    } via_wen_t;

endpackage

// File: rtl/cache_2vias_wb_if.sv
// Processor req/done and backing-memory req/ack buses of the cache.
interface cache_2vias_wb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        output cpu_busy, cpu_done, cpu_rdata, cpu_hit,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
        input  cpu_busy, cpu_done, cpu_rdata, cpu_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_2vias_wb_via.sv
// Storage for one cache way: resettable valid/dirty bits, unreset tag/data
// arrays, combinational read and one synchronous write port.
module cache_via
    import cache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 2,
    parameter int DATA_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_val_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DATA_W-1:0]  rd_data_o,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  via_wen_t           wen_i,
    input  logic               wr_val_i,
    input  logic               wr_dirty_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]   val_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            val_q   <= '0;
            dirty_q <= '0;
        end else begin
            if (wen_i.val)   val_q[wr_idx_i]   <= wr_val_i;
            if (wen_i.dirty) dirty_q[wr_idx_i] <= wr_dirty_i;
        end
    end

    always_ff @(posedge clock) begin
        if (wen_i.tag)  tag_q[wr_idx_i]  <= wr_tag_i;
        if (wen_i.data) data_q[wr_idx_i] <= wr_data_i;
    end

    assign rd_val_o   = val_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/cache_2vias_wb.sv
// 2-way set-associative write-back/write-allocate cache controller with true
// LRU per set, miss FSM toward backing memory and saturating statistics.
module cache_2vias_wb
    import cache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 2,
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    cache_2vias_wb_if.slave  bus,
    output logic             dirty_wb,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);
    localparam int ADDR_W = TAG_W + INDEX_W;
    localparam int SETS   = 1 << INDEX_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                victim_q, victim_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic                done_q, done_d, hit_q, hit_d, dirty_wb_q, dirty_wb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic                hit_inc, miss_inc, wb_inc;

    logic [INDEX_W-1:0]                  idx;
    logic [TAG_W-1:0]                    tag;
    logic [NUM_VIAS-1:0]                 rd_val, rd_dirty, hit_way;
    logic [NUM_VIAS-1:0][TAG_W-1:0]      rd_tag;
    logic [NUM_VIAS-1:0][DATA_W-1:0]     rd_data;
    via_wen_t                            wen [NUM_VIAS];
    logic                                wr_dirty;
    logic [DATA_W-1:0]                   wr_data;
    logic                                hit_sel, miss_victim;

    assign idx = addr_q[INDEX_W-1:0];
    assign tag = addr_q[ADDR_W-1:INDEX_W];

    generate
        for (genvar w = 0; w < NUM_VIAS; w++) begin : g_via
            cache_via #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_via (
                .clock      (clock),
                .reset      (reset),
                .rd_idx_i   (idx),
                .rd_val_o   (rd_val[w]),
                .rd_dirty_o (rd_dirty[w]),
                .rd_tag_o   (rd_tag[w]),
                .rd_data_o  (rd_data[w]),
                .wr_idx_i   (idx),
                .wen_i      (wen[w]),
                .wr_val_i   (1'b1),
                .wr_dirty_i (wr_dirty),
                .wr_tag_i   (tag),
                .wr_data_i  (wr_data)
            );
            assign hit_way[w] = rd_val[w] && (rd_tag[w] == tag);
        end
    endgenerate

    // Way 0 wins a double match; invalid ways are filled before evicting LRU.
    assign hit_sel     = ~hit_way[0];
    assign miss_victim = !rd_val[0] ? 1'b0 : (!rd_val[1] ? 1'b1 : lru_q[idx]);

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        lru_d      = lru_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        hit_d      = 1'b0;
        dirty_wb_d = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        wb_inc     = 1'b0;
        for (int w = 0; w < NUM_VIAS; w++) wen[w] = '0;
        wr_dirty      = 1'b0;
        wr_data       = wdata_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            IDLE: if (bus.cpu_req) state_d = LOOKUP;
            LOOKUP: begin
                if (|hit_way) begin
                    hit_inc    = 1'b1;
                    done_d     = 1'b1;
                    hit_d      = 1'b1;
                    lru_d[idx] = ~hit_sel;
                    state_d    = IDLE;
                    if (we_q) begin
                        wen[hit_sel].data  = 1'b1;
                        wen[hit_sel].dirty = 1'b1;
                        wr_dirty           = 1'b1;
                    end else begin
                        rdata_d = rd_data[hit_sel];
                    end
                end else begin
                    miss_inc = 1'b1;
                    victim_d = miss_victim;
                    state_d  = (rd_val[miss_victim] && rd_dirty[miss_victim]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {rd_tag[victim_q], idx};
                bus.mem_wdata = rd_data[victim_q];
                if (bus.mem_ack) begin
                    dirty_wb_d = 1'b1;
                    wb_inc     = 1'b1;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_q;
                if (bus.mem_ack) begin
                    wen[victim_q] = '{val: 1'b1, dirty: 1'b1, tag: 1'b1, data: 1'b1};
                    wr_dirty      = we_q;
                    wr_data       = we_q ? wdata_q : bus.mem_rdata;
                    if (!we_q) rdata_d = bus.mem_rdata;
                    lru_d[idx]    = ~victim_q;
                    done_d        = 1'b1;
                    state_d       = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            dirty_wb_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            lru_q      <= lru_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            rdata_q    <= rdata_d;
            dirty_wb_q <= dirty_wb_d;
            if (state_q == IDLE && bus.cpu_req) begin
                addr_q  <= bus.cpu_addr;
                we_q    <= bus.cpu_we;
                wdata_q <= bus.cpu_wdata;
            end
            if (hit_inc  && hit_cnt_q  != '1) hit_cnt_q  <= hit_cnt_q  + 1'b1;
            if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (wb_inc   && wb_cnt_q   != '1) wb_cnt_q   <= wb_cnt_q   + 1'b1;
        end
    end

    assign bus.cpu_busy  = (state_q != IDLE);
    assign bus.cpu_done  = done_q;
    assign bus.cpu_hit   = hit_q;
    assign bus.cpu_rdata = rdata_q;
    assign dirty_wb      = dirty_wb_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
    assign wb_count      = wb_cnt_q;

endmodule

// File: tb/tb_cache_2vias_wb.sv
// Bench for cache_2vias_wb: directed table, multi-cycle corner sequences and
// random traffic against a recency-list cache model and a memory array.
module tb_cache_2vias_wb;
    localparam int INDEX_W = 3, TAG_W = 2, DATA_W = 4, CNT_W = 2;
    localparam int ADDR_W = TAG_W + INDEX_W;
    localparam int SETS = 1 << INDEX_W;
    localparam int SAT = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             dirty_wb;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    cache_2vias_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    cache_2vias_wb #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .dirty_wb   (dirty_wb),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Backing memory plus a per-set recency list (entry 0 = most recently used).
    logic [DATA_W-1:0] mem     [32];
    int                m_cnt   [SETS];
    logic [TAG_W-1:0]  m_tag   [SETS][2];
    logic [DATA_W-1:0] m_data  [SETS][2];
    logic              m_dirty [SETS][2];
    int                m_hits, m_miss, m_wbs;
    logic [DATA_W-1:0] m_rdata;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
        m_hits = 0; m_miss = 0; m_wbs = 0; m_rdata = '0;
    endtask

    task automatic model_step(input logic we, input logic [4:0] addr, input logic [3:0] wd,
                              output logic e_hit, output int e_wb,
                              output logic [4:0] e_wba, output logic [3:0] e_wbd);
        int s, pos;
        logic [1:0] tg;
        logic [1:0] t0; logic [3:0] d0; logic y0;
        s = int'(addr[2:0]); tg = addr[4:3]; pos = -1;
        e_wb = 0; e_wba = '0; e_wbd = '0;
        for (int p = m_cnt[s] - 1; p >= 0; p--) if (m_tag[s][p] == tg) pos = p;
        if (pos >= 0) begin
            e_hit = 1'b1;
            if (m_hits < SAT) m_hits++;
            if (pos == 1) begin
                t0 = m_tag[s][0]; d0 = m_data[s][0]; y0 = m_dirty[s][0];
                m_tag[s][0] = m_tag[s][1]; m_data[s][0] = m_data[s][1]; m_dirty[s][0] = m_dirty[s][1];
                m_tag[s][1] = t0; m_data[s][1] = d0; m_dirty[s][1] = y0;
            end
        end else begin
            e_hit = 1'b0;
            if (m_miss < SAT) m_miss++;
            if (m_cnt[s] == 2 && m_dirty[s][1]) begin
                e_wb = 1; e_wba = {m_tag[s][1], addr[2:0]}; e_wbd = m_data[s][1];
                mem[e_wba] = e_wbd;
                if (m_wbs < SAT) m_wbs++;
            end
            if (m_cnt[s] >= 1) begin
                m_tag[s][1] = m_tag[s][0]; m_data[s][1] = m_data[s][0]; m_dirty[s][1] = m_dirty[s][0];
            end
            if (m_cnt[s] < 2) m_cnt[s]++;
            m_tag[s][0] = tg; m_data[s][0] = mem[addr]; m_dirty[s][0] = 1'b0;
        end
        if (we) begin m_data[s][0] = wd; m_dirty[s][0] = 1'b1; end
        else m_rdata = m_data[s][0];
    endtask

    // One processor transaction with a responding memory; ack after dly waiting cycles.
    task automatic access(input logic we, input logic [4:0] addr, input logic [3:0] wd,
                          input int dly, input bit toggle,
                          output logic o_hit, output logic [3:0] o_rdata, output int o_wb);
        logic e_hit; int e_wb; logic [4:0] e_wba; logic [3:0] e_wbd;
        int phase, waitc, lat; bit got;
        model_step(we, addr, wd, e_hit, e_wb, e_wba, e_wbd);
        @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        @(negedge clock);
        bus.cpu_req = 1'b0;
        phase = (e_wb != 0) ? 0 : 1; waitc = 0; got = 0; lat = 0; o_wb = 0;
        o_hit = 1'bx; o_rdata = 'x;
        for (int i = 0; i < 60 && !got; i++) begin
            if (i > 0) @(negedge clock);
            bus.mem_ack = 1'b0;
            o_wb += int'(dirty_wb);
            if (bus.cpu_done) begin
                got = 1; lat = i; o_hit = bus.cpu_hit; o_rdata = bus.cpu_rdata;
                bus.cpu_req = 1'b0;
                check("mem_req_after_done", bus.mem_req, 0);
            end else begin
                if (bus.mem_req) begin
                    check("extra_mem_req", phase < 2, 1);
                    check("mem_we", bus.mem_we, phase == 0);
                    check("mem_addr", bus.mem_addr, (phase == 0) ? e_wba : addr);
                    if (phase == 0) check("mem_wdata", bus.mem_wdata, e_wbd);
                    waitc++;
                    if (waitc > dly) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = (phase == 0) ? 4'($urandom) : mem[bus.mem_addr];
                        phase++; waitc = 0;
                    end
                end
                if (toggle) begin
                    bus.cpu_req = 1'($urandom); bus.cpu_we = 1'($urandom); bus.cpu_addr = 5'($urandom);
                end
            end
        end
        if (!got) check("done_timeout", 0, 1);
        else begin
            check("cpu_hit", o_hit, e_hit);
            check("cpu_rdata", o_rdata, m_rdata);
            if (e_hit) check("hit_latency", lat, 1);
        end
        @(negedge clock);
        o_wb += int'(dirty_wb);
        check("dirty_wb_pulses", o_wb, e_wb);
        check("single_done", bus.cpu_done, 0);
        check("idle_busy", bus.cpu_busy, 0);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_miss);
        check("wb_count", wb_count, m_wbs);
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.cpu_req = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [3:0] wd;
        int         dly;
        logic       exp_hit;
        logic [3:0] exp_rdata;
        int         exp_wb;
    } vec_t;
    vec_t vec [5];

    initial begin
        logic h; logic [3:0] rd; int wb; bit seen;
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        for (int a = 0; a < 32; a++) mem[a] = 4'($urandom);
        mem[5'b01_010] = 4'hA;
        mem[5'b11_010] = 4'h3;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_busy", bus.cpu_busy, 0);
        check("rst_done", bus.cpu_done, 0);
        check("rst_hit", bus.cpu_hit, 0);
        check("rst_rdata", bus.cpu_rdata, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_dirty_wb", dirty_wb, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_wb_count", wb_count, 0);
        reset = 1'b0;

        vec[0] = '{1'b0, 5'b01_010, 4'h0, 0, 1'b0, 4'hA, 0};  // cold read miss
        vec[1] = '{1'b0, 5'b01_010, 4'h0, 0, 1'b1, 4'hA, 0};  // same read hits
        vec[2] = '{1'b1, 5'b10_010, 4'h5, 1, 1'b0, 4'hA, 0};  // write miss, rdata held
        vec[3] = '{1'b0, 5'b01_010, 4'h0, 0, 1'b1, 4'hA, 0};  // hit makes tag 2 LRU
        vec[4] = '{1'b0, 5'b11_010, 4'h0, 2, 1'b0, 4'h3, 1};  // dirty eviction of tag 2
        for (int i = 0; i < 5; i++) begin
            access(vec[i].we, vec[i].addr, vec[i].wd, vec[i].dly, 1'b0, h, rd, wb);
            check($sformatf("vec%0d_hit", i), h, vec[i].exp_hit);
            check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
            check($sformatf("vec%0d_wb", i), wb, vec[i].exp_wb);
        end
        check("vec_wb_count", wb_count, 1);
        check("vec_mem_wb_data", mem[5'b10_010], 4'h5);

        // Slow memory with processor requests toggling during the miss.
        access(1'b0, 5'b00_101, 4'h0, 5, 1'b1, h, rd, wb);
        check("slow_miss_hit", h, 0);

        // Hit counter saturation.
        for (int i = 0; i < 5; i++) access(1'b0, 5'b11_010, 4'h0, 0, 1'b0, h, rd, wb);
        check("hit_saturated", hit_count, SAT);

        for (int i = 0; i < 150; i++)
            access(1'($urandom), {2'($urandom), 3'($urandom_range(0, 2))}, 4'($urandom),
                   $urandom_range(0, 3), 1'b0, h, rd, wb);

        // Reset while waiting in refill abandons the transaction.
        do_reset();
        @(negedge clock);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 5'b01_100;
        @(negedge clock);
        bus.cpu_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (bus.mem_req) seen = 1;
        end
        check("refill_reached", seen, 1);
        reset = 1'b1;
        #1;
        check("midreset_mem_req", bus.mem_req, 0);
        check("midreset_busy", bus.cpu_busy, 0);
        @(negedge clock);
        check("midreset_done", bus.cpu_done, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_done", bus.cpu_done, 0);
        model_reset();
        access(1'b0, 5'b01_100, 4'h0, 0, 1'b0, h, rd, wb);
        check("reread_misses", h, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
